// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with a hardware clear sweep.
//
// One write port and NUM_RD combinational read ports. A clear sweep zeroes
// the array one entry per cycle. The sweep runs out of reset and whenever
// clr is sampled while idle. While the sweep runs, busy is high, reads
// return zero and writes are dropped, with a one-cycle wr_drop pulse.
//
// Optional feature: define REGFILE_BYPASS_EN to forward wr_data to any read
// port whose address matches an accepted same-cycle write.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous active-high reset; starts a fresh sweep
//   clr      - request a full-array clear sweep (honoured only while idle)
//   wr_en    - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  - packed read data, port k at [k*DATA_W +: DATA_W]
//   busy     - high while the clear sweep is in progress
//   wr_drop  - one-cycle pulse after a write rejected because of busy
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                wr_drop_q, wr_drop_d;
    logic                clr_we;
    logic                wr_we;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Next-state, sweep counter and write qualification.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = 1'b0;
        clr_we    = 1'b0;
        wr_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
                // Writes to a hardwired zero entry vanish without a drop pulse.
                if (wr_en && !(ZERO_EN && (wr_addr == '0))) begin
                    wr_we = 1'b1;
                end
            end
            StClear: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + ADDR_W'(1);
                // The last entry is cleared on this cycle, so leave the sweep.
                if (&cnt_q) begin
                    state_d = StIdle;
                end
                // clr is ignored here; only writes are rejected and flagged.
                if (wr_en) begin
                    wr_drop_d = 1'b1;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces a fresh sweep from entry 0 and overrides clr and wr_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage array: no entry is touched while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
            end else if (wr_we) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    assign busy    = (state_q == StClear);
    assign wr_drop = wr_drop_q;

    // Combinational read ports.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        // wr_we already excludes busy and discarded zero-entry writes.
        logic fwd;
        assign fwd = wr_we && (ra == wr_addr);
        assign rv  = fwd ? wr_data : mem[ra];
`else
        assign rv = mem[ra];
`endif

        assign rd_data[k*DATA_W +: DATA_W] = (busy || (ZERO_EN && (ra == '0))) ? '0 : rv;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk;
    logic        reset;

    // Default-parameter instance.
    logic        clr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        busy;
    logic        wr_drop;

    // Corner-parameter instance: DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=0.
    logic        clr2;
    logic        wr_en2;
    logic [2:0]  wr_addr2;
    logic [15:0] wr_data2;
    logic [11:0] rd_addr2;
    logic [63:0] rd_data2;
    logic        busy2;
    logic        wr_drop2;

    int n_total;
    int n_pass;
    int n1;
    int n2;

    reg_file_mp u_dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    reg_file_mp #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .NUM_RD   (4),
        .ZERO_REG (0)
    ) u_dut2 (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr2),
        .wr_en   (wr_en2),
        .wr_addr (wr_addr2),
        .wr_data (wr_data2),
        .rd_addr (rd_addr2),
        .rd_data (rd_data2),
        .busy    (busy2),
        .wr_drop (wr_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high on each instance until both are idle.
    task automatic count_busy(output int c1, output int c2, input int clr_at);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy && !busy2) break;
            if (busy)  c1++;
            if (busy2) c2++;
            clr = (i == clr_at);
            tick();
            clr = 1'b0;
        end
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset    = 1'b1;
        clr      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        clr2     = 1'b0;
        wr_en2   = 1'b0;
        wr_addr2 = '0;
        wr_data2 = '0;
        rd_addr2 = '0;

        // Reset, then sweep length on both instances.
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_wr_drop", 64'(wr_drop), 64'd0);
        check("rst_busy2", 64'(busy2), 64'd1);
        reset = 1'b0;
        count_busy(n1, n2, -1);
        check("sweep_len", 64'(n1), 64'd32);
        check("sweep_len2", 64'(n2), 64'd8);
        rd_addr = {5'd31, 5'd5};
        #1;
        check("post_rst_rd0", 64'(rd_data[31:0]), 64'd0);
        check("post_rst_rd1", 64'(rd_data[63:32]), 64'd0);

        // Write / readback.
        wr_en = 1'b1; wr_addr = 5'd7;  wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 5'd31; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd31, 5'd7};
        #1;
        check("rd_7", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check("rd_31", 64'(rd_data[63:32]), 64'h12345678);

        // Zero register.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr = {5'd7, 5'd0};
        #1;
        check("zero_same_cyc", 64'(rd_data[31:0]), 64'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("zero_rd", 64'(rd_data[31:0]), 64'd0);
        check("zero_no_drop", 64'(wr_drop), 64'd0);

        // Same-cycle read of the address being written.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D;
        tick();
        wr_data = 32'hA5A5A5A5;
        rd_addr = {5'd7, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cyc_9", 64'(rd_data[31:0]), 64'hA5A5A5A5);
`else
        check("same_cyc_9", 64'(rd_data[31:0]), 64'h0BADF00D);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("next_cyc_9", 64'(rd_data[31:0]), 64'hA5A5A5A5);

        // Dropped write during a clr sweep; write lands after entry 3 is cleared.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rd_addr = {5'd9, 5'd7};
        #1;
        check("clr_busy", 64'(busy), 64'd1);
        check("busy_rd_zero", 64'(rd_data[31:0]), 64'd0);
        repeat (10) tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        check("drop_pulse", 64'(wr_drop), 64'd1);
        tick();
        check("drop_clear", 64'(wr_drop), 64'd0);
        count_busy(n1, n2, -1);
        check("clr_sweep_rest", 64'(n1), 64'd20);
        rd_addr = {5'd7, 5'd3};
        #1;
        check("dropped_rd_3", 64'(rd_data[31:0]), 64'd0);
        check("swept_rd_7", 64'(rd_data[63:32]), 64'd0);

        // Mid-sweep reset, with clr and wr_en held during reset.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        reset = 1'b1; clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
        tick();
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_no_drop", 64'(wr_drop), 64'd0);
        reset = 1'b0; clr = 1'b0; wr_en = 1'b0;
        // clr pulsed mid-sweep must not lengthen it.
        count_busy(n1, n2, 5);
        check("midrst_len", 64'(n1), 64'd32);
        rd_addr = {5'd0, 5'd9};
        #1;
        check("midrst_rd_9", 64'(rd_data[31:0]), 64'd0);

        // Parameter corner: entry 0 is ordinary storage.
        wr_en2 = 1'b1; wr_addr2 = 3'd0; wr_data2 = 16'hBEEF;
        tick();
        wr_en2 = 1'b0;
        rd_addr2 = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("corner_rd%0d", k), 64'(rd_data2[k*16 +: 16]), 64'hBEEF);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
